fetch_prefetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle datapath: issues word-aligned fetch requests to a latency-tolerant instruction memory, buffers returned words in a DEPTH-entry in-order queue, and presents one instruction plus its PC per handshake to the decode/controller stage. Branch/jump redirects from the datapath flush the queue and discard in-flight responses. Decouples variable instruction-memory latency from the execute stage.

---
 rtl/fetch_prefetch_queue.sv | 162 ++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests, in-order response buffering, redirect flush.
// Optional FETCH_STATS_EN adds saturating DropCount/FlushCount statistics outputs.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstPC,
`ifdef FETCH_STATS_EN
    output logic [15:0] DropCount,
    output logic [15:0] FlushCount,
`endif
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   enq_pc_q, enq_pc_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [CW:0]   credit;
    logic          req_fire, deq_fire, enq;
    logic          unused_redirect_bits;

    // Queued plus in-flight words never exceed DEPTH, so every response has a free slot.
    assign credit       = {1'b0, count_q} + {1'b0, outst_q};
    assign ImemReqValid = !Reset && (state_q == RUN) && (credit < DEPTH_C);
    assign ImemReqAddr  = fetch_pc_q;
    assign InstValid    = (state_q == RUN) && (count_q != '0);
    assign Instruction  = (count_q != '0) ? word_q[head_q] : '0;
    assign InstPC       = (count_q != '0) ? pc_q[head_q] : enq_pc_q;

    assign req_fire = ImemReqValid && ImemReqReady;
    assign deq_fire = InstValid && InstReady;
    assign unused_redirect_bits = ^RedirectPC[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        enq_pc_d   = enq_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_d     = drop_q;
        enq        = 1'b0;
        outst_d    = outst_q + CW'(req_fire) - CW'(ImemRspValid);

        if (RedirectValid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = {RedirectPC[31:2], 2'b00};
            enq_pc_d   = {RedirectPC[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            if (ImemRspValid) begin
                drop_d = drop_q - CW'(1);
            end
            if (drop_d == '0) begin
                state_d = RUN;
            end
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (ImemRspValid) begin
                enq      = 1'b1;
                tail_d   = tail_q + PW'(1);
                enq_pc_d = enq_pc_q + 32'd4;
            end
            if (deq_fire) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq_fire);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            enq_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            enq_pc_q   <= enq_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && enq) begin
            word_q[tail_q] <= ImemRspData;
            pc_q[tail_q]   <= enq_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] drop_cnt_q, flush_cnt_q;
    logic [CW:0] drop_inc;
    logic [16:0] drop_sum;

    // A redirect throws away the unconsumed queue entries plus any word arriving that cycle.
    always_comb begin
        drop_inc = '0;
        if (RedirectValid) begin
            drop_inc = {1'b0, count_q} - (CW+1)'(deq_fire) + (CW+1)'(ImemRspValid);
        end else if (state_q == FLUSH) begin
            drop_inc = (CW+1)'(ImemRspValid);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_inc);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            drop_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (RedirectValid && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign DropCount  = drop_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: in-order memory model, PC/word scoreboard, reset/redirect/wrap checks.
module tb_fetch_prefetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ImemReqValid;
    logic        ImemReqReady = 1'b0;
    logic [31:0] ImemReqAddr;
    logic        ImemRspValid = 1'b0;
    logic [31:0] ImemRspData = '0;
    logic        InstValid;
    logic        InstReady = 1'b0;
    logic [31:0] Instruction;
    logic [31:0] InstPC;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectPC = '0;
`ifdef FETCH_STATS_EN
    logic [15:0] DropCount;
    logic [15:0] FlushCount;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int mem_lat = 1;

    logic [31:0] exp_q[$];
    logic [31:0] req_addr_q[$];
    logic [31:0] pend_addr_q[$];
    int          pend_due_q[$];

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .ImemReqValid(ImemReqValid),
        .ImemReqReady(ImemReqReady),
        .ImemReqAddr(ImemReqAddr),
        .ImemRspValid(ImemRspValid),
        .ImemRspData(ImemRspData),
        .InstValid(InstValid),
        .InstReady(InstReady),
        .Instruction(Instruction),
        .InstPC(InstPC),
`ifdef FETCH_STATS_EN
        .DropCount(DropCount),
        .FlushCount(FlushCount),
`endif
        .RedirectValid(RedirectValid),
        .RedirectPC(RedirectPC)
    );

    // Clock / cycle counter / watchdog
    always #5 Clock = ~Clock;

    initial begin
        forever begin
            @(posedge Clock);
            cyc++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Instruction memory: fixed latency, in order, word = ~address
    initial begin
        forever begin
            @(negedge Clock);
            #1;
            ImemRspValid = 1'b0;
            ImemRspData  = '0;
            ImemReqReady = 1'b1;
            if (Reset) begin
                pend_addr_q.delete();
                pend_due_q.delete();
            end else begin
                if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc + 1) begin
                    ImemRspValid = 1'b1;
                    ImemRspData  = ~pend_addr_q[0];
                    void'(pend_addr_q.pop_front());
                    void'(pend_due_q.pop_front());
                end
                if (ImemReqValid === 1'b1) begin
                    check32("req_align", {30'd0, ImemReqAddr[1:0]}, 32'd0);
                    pend_addr_q.push_back(ImemReqAddr);
                    pend_due_q.push_back(cyc + 1 + mem_lat);
                    req_addr_q.push_back(ImemReqAddr);
                end
            end
        end
    end

    // Monitor: every dequeue handshake pops one expected PC
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge Clock);
            #2;
            if (Reset === 1'b0 && InstValid === 1'b1 && InstReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: actual pc %h, none required", InstPC);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check32("inst_pc", InstPC, exp_pc);
                    check32("inst_word", Instruction, ~exp_pc);
                end
            end
        end
    end

    // Driver tasks
    task automatic do_reset(input int lat);
        @(negedge Clock);
        Reset         = 1'b1;
        InstReady     = 1'b0;
        RedirectValid = 1'b0;
        RedirectPC    = '0;
        mem_lat       = lat;
        exp_q.delete();
        req_addr_q.delete();
        #3;
        check32("rst_req_valid_during", {31'd0, ImemReqValid}, 32'd0);
        @(negedge Clock);
        Reset   = 1'b0;
        rst_cyc = cyc;
        #3;
        check32("rst_req_valid_after", {31'd0, ImemReqValid}, 32'd1);
        check32("rst_req_addr", ImemReqAddr, RESET_PC);
        check32("rst_inst_valid", {31'd0, InstValid}, 32'd0);
        check32("rst_instruction", Instruction, 32'd0);
        check32("rst_inst_pc", InstPC, RESET_PC);
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        InstReady = 1'b0;
        check32(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Latency 1, always ready: one instruction per cycle after a 2-cycle fill
        do_reset(1);
        @(negedge Clock);
        InstReady = 1'b1;
        push_seq(32'h0, 10);
        wait_drain("stream_drain", 40);
        check32("stream_cycles", cyc - rst_cyc, 32'd12);

        // Stalled consumer: exactly DEPTH requests, then fetch resumes at 16
        do_reset(1);
        repeat (8) @(negedge Clock);
        #3;
        check32("stall_req_count", req_addr_q.size(), 32'd4);
        check32("stall_req_valid", {31'd0, ImemReqValid}, 32'd0);
        check32("stall_inst_valid", {31'd0, InstValid}, 32'd1);
        check32("stall_head_pc", InstPC, 32'h0);
        @(negedge Clock);
        push_seq(32'h0, 6);
        InstReady = 1'b1;
        wait_drain("stall_drain", 40);
        check32("resume_addr", (req_addr_q.size() > 4) ? req_addr_q[4] : 32'hDEAD_BEEF, 32'h10);

        // Redirect with 3 words in flight at latency 3
        do_reset(3);
        repeat (2) @(negedge Clock);
        RedirectValid = 1'b1;
        RedirectPC    = 32'h0000_0103;
        @(negedge Clock);
        RedirectValid = 1'b0;
        #3;
        check32("flush_req_valid", {31'd0, ImemReqValid}, 32'd0);
        check32("flush_inst_valid", {31'd0, InstValid}, 32'd0);
        repeat (2) @(negedge Clock);
        #3;
        check32("flush_hold", {31'd0, ImemReqValid}, 32'd0);
        @(negedge Clock);
        InstReady = 1'b1;
        push_seq(32'h100, 3);
        #3;
        check32("redir_req_valid", {31'd0, ImemReqValid}, 32'd1);
        check32("redir_req_addr", ImemReqAddr, 32'h100);
        wait_drain("redir_drain", 40);
        check32("redir_first_req", (req_addr_q.size() > 3) ? req_addr_q[3] : 32'hDEAD_BEEF, 32'h100);
`ifdef FETCH_STATS_EN
        check32("stats_drop_a", {16'd0, DropCount}, 32'd3);
        check32("stats_flush_a", {16'd0, FlushCount}, 32'd1);
`endif

        // Redirect coinciding with a dequeue and a response
        do_reset(1);
        @(negedge Clock);
        @(negedge Clock);
        InstReady     = 1'b1;
        RedirectValid = 1'b1;
        RedirectPC    = 32'h0000_0200;
        exp_q.push_back(32'h0);
        @(negedge Clock);
        InstReady     = 1'b0;
        RedirectValid = 1'b0;
        #3;
        check32("coinc_consumed", exp_q.size(), 32'd0);
        check32("coinc_inst_valid", {31'd0, InstValid}, 32'd0);
        check32("coinc_req_valid", {31'd0, ImemReqValid}, 32'd0);
        @(negedge Clock);
        #3;
        check32("coinc_resume_valid", {31'd0, ImemReqValid}, 32'd1);
        check32("coinc_resume_addr", ImemReqAddr, 32'h200);
        check32("coinc_still_empty", {31'd0, InstValid}, 32'd0);
        @(negedge Clock);
        push_seq(32'h200, 2);
        InstReady = 1'b1;
        wait_drain("coinc_drain", 40);
`ifdef FETCH_STATS_EN
        check32("stats_drop_b", {16'd0, DropCount}, 32'd2);
        check32("stats_flush_b", {16'd0, FlushCount}, 32'd1);
`endif

        // Fetch address wraps past 0xFFFF_FFFC; low redirect bits ignored
        do_reset(1);
        @(negedge Clock);
        RedirectValid = 1'b1;
        RedirectPC    = 32'hFFFF_FFFA;
        @(negedge Clock);
        RedirectValid = 1'b0;
        InstReady     = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        wait_drain("wrap_drain", 40);
        check32("wrap_addr", (req_addr_q.size() > 4) ? req_addr_q[4] : 32'hDEAD_BEEF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
